// File: rtl/fetch_unit.sv
// Instruction fetch stage with SPARC-style PC/nPC delayed control transfer.
// Drives a combinational ROM from the PC and captures the returned word into IF/ID.
module fetch_unit #(
  parameter int          ADDR_W   = 9,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              le,
  input  logic              branch_taken,
  input  logic [31:0]       ta,
  input  logic              flush,
  input  logic [31:0]       rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       pc,
  output logic [31:0]       npc,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc,
  output logic              ifid_valid
);

  // state  | meaning
  // BOOT   | out of reset, nothing fetched yet; first le=1 edge fetches and leaves
  // RUN    | steady-state fetch; PC/nPC advance on every le=1 edge
  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc;
  logic        r_ifid_valid;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_npc_nxt;
  logic [31:0] w_ifid_instr_nxt;
  logic [31:0] w_ifid_pc_nxt;
  logic        w_ifid_valid_nxt;
  logic [31:0] w_npc_seq;

  assign w_npc_seq = r_npc + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  if (le) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // BOOT and RUN share the same datapath update; only the state transition differs.
  always_comb begin
    w_pc_nxt         = r_pc;
    w_npc_nxt        = r_npc;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_valid_nxt = r_ifid_valid;
    if (le) begin
      w_pc_nxt         = r_npc;
      w_npc_nxt        = branch_taken ? ta : w_npc_seq;
      w_ifid_instr_nxt = rom_data;
      w_ifid_pc_nxt    = r_pc;
      w_ifid_valid_nxt = 1'b1;
    end
    if (flush) begin
      w_ifid_instr_nxt = 32'h0;
      w_ifid_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= PC_RESET;
      r_npc        <= PC_RESET + 32'd4;
      r_ifid_instr <= 32'h0;
      r_ifid_pc    <= 32'h0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_npc        <= w_npc_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
    end
  end

  assign rom_addr   = r_pc[ADDR_W-1:0];
  assign pc         = r_pc;
  assign npc        = r_npc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a PC/nPC reference model driven by a testbench-side ROM.
module tb_fetch_unit;
  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              le;
  logic              branch_taken;
  logic [31:0]       ta;
  logic              flush;
  logic [31:0]       rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       pc;
  logic [31:0]       npc;
  logic [31:0]       ifid_instr;
  logic [31:0]       ifid_pc;
  logic              ifid_valid;

  logic [31:0] rom [0:127];

  logic [31:0] m_pc, m_npc, m_instr, m_ifpc;
  logic        m_valid;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(ADDR_W), .PC_RESET(32'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .le           (le),
    .branch_taken (branch_taken),
    .ta           (ta),
    .flush        (flush),
    .rom_data     (rom_data),
    .rom_addr     (rom_addr),
    .pc           (pc),
    .npc          (npc),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
    .ifid_valid   (ifid_valid)
  );

  always #5 clk = ~clk;

  // 512-byte ROM, word-addressed by the byte address bits above the word offset
  assign rom_data = rom[rom_addr[ADDR_W-1:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},       pc,                   m_pc);
    check({tag, ".npc"},      npc,                  m_npc);
    check({tag, ".instr"},    ifid_instr,           m_instr);
    check({tag, ".ifid_pc"},  ifid_pc,              m_ifpc);
    check({tag, ".valid"},    {31'h0, ifid_valid},  {31'h0, m_valid});
    check({tag, ".rom_addr"}, {23'h0, rom_addr},    {23'h0, m_pc[8:0]});
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_npc   = 32'h4;
    m_instr = 32'h0;
    m_ifpc  = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic set_in(input logic i_le, input logic i_bt, input logic [31:0] i_ta, input logic i_fl);
    le           = i_le;
    branch_taken = i_bt;
    ta           = i_ta;
    flush        = i_fl;
  endtask

  // One rising edge: model the architectural effect of the current inputs, then compare.
  task automatic tick(input string tag);
    logic [31:0] n_pc, n_npc, n_instr, n_ifpc;
    logic        n_valid;
    n_pc = m_pc; n_npc = m_npc; n_instr = m_instr; n_ifpc = m_ifpc; n_valid = m_valid;
    if (le) begin
      n_pc    = m_npc;
      n_npc   = branch_taken ? ta : m_npc + 32'd4;
      n_instr = rom[m_pc[8:2]];
      n_ifpc  = m_pc;
      n_valid = 1'b1;
    end
    if (flush) begin
      n_instr = 32'h0;
      n_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_npc = n_npc; m_instr = n_instr; m_ifpc = n_ifpc; m_valid = n_valid;
    check_all(tag);
  endtask

  // Reset pulse placed between clock edges, released well before the next edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    #2;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    rom[0] = 32'hA000_0001;
    rom[1] = 32'hA000_0002;
    rom[2] = 32'hA000_0003;
    rom[3] = 32'hA000_0004;
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    #2;
    model_reset();
    check_all("rst_init");
    @(posedge clk);
    #2;
    check_all("rst_held");
    reset = 1'b0;

    // BOOT holds under stall, ignoring branches
    set_in(1'b0, 1'b1, 32'h100, 1'b0);
    tick("boot_stall0");
    tick("boot_stall1");
    check("boot_pc", pc, 32'h0);
    check("boot_valid", {31'h0, ifid_valid}, 32'h0);

    // sequential fetch
    set_in(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick("seq");
      check("seq_instr", ifid_instr, 32'hA000_0001 + i);
      check("seq_ifpc", ifid_pc, 32'(i * 4));
    end
    check("seq_pc_end", pc, 32'd16);
    check("seq_npc_end", npc, 32'd20);

    // delayed branch from pc=8
    do_reset();
    set_in(1'b1, 1'b0, 32'h0, 1'b0);
    tick("br_pre0");
    tick("br_pre1");
    check("br_at_pc", pc, 32'd8);
    set_in(1'b1, 1'b1, 32'h40, 1'b0);
    tick("br_take");
    check("br_slot_pc", pc, 32'd12);
    check("br_slot_npc", npc, 32'h40);
    check("br_ifpc0", ifid_pc, 32'd8);
    set_in(1'b1, 1'b0, 32'h0, 1'b0);
    tick("br_tgt");
    check("br_tgt_pc", pc, 32'h40);
    check("br_tgt_npc", npc, 32'h44);
    check("br_ifpc1", ifid_pc, 32'd12);
    tick("br_run");
    check("br_run_pc", pc, 32'h44);

    // async reset mid-run with a branch pending, then restart from address 0
    set_in(1'b1, 1'b1, 32'h80, 1'b0);
    do_reset();
    check("rst_mid_pc", pc, 32'h0);
    check("rst_mid_npc", npc, 32'h4);
    set_in(1'b1, 1'b0, 32'h0, 1'b0);
    tick("rst_restart");
    check("rst_restart_instr", ifid_instr, 32'hA000_0001);
    check("rst_restart_ifpc", ifid_pc, 32'h0);

    // stall at pc=4 with branch pulses ignored
    do_reset();
    set_in(1'b1, 1'b0, 32'h0, 1'b0);
    tick("stall_pre");
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, i[0] ? 1'b0 : 1'b1, $urandom, 1'b0);
      tick("stall");
    end
    check("stall_pc", pc, 32'd4);
    check("stall_npc", npc, 32'd8);
    check("stall_instr", ifid_instr, 32'hA000_0001);
    check("stall_valid", {31'h0, ifid_valid}, 32'h1);

    // flush with and without load enable
    do_reset();
    set_in(1'b1, 1'b0, 32'h0, 1'b0);
    tick("fl_pre0");
    tick("fl_pre1");
    set_in(1'b1, 1'b0, 32'h0, 1'b1);
    tick("fl_le1");
    check("fl_le1_instr", ifid_instr, 32'h0);
    check("fl_le1_valid", {31'h0, ifid_valid}, 32'h0);
    check("fl_le1_ifpc", ifid_pc, 32'd8);
    check("fl_le1_pc", pc, 32'd12);
    set_in(1'b1, 1'b0, 32'h0, 1'b0);
    tick("fl_refill");
    set_in(1'b0, 1'b1, 32'h200, 1'b1);
    tick("fl_le0");
    check("fl_le0_instr", ifid_instr, 32'h0);
    check("fl_le0_valid", {31'h0, ifid_valid}, 32'h0);
    check("fl_le0_pc", pc, 32'd16);
    check("fl_le0_ifpc", ifid_pc, 32'd12);

    // address wrap, 32-bit npc wrap, misaligned target
    do_reset();
    set_in(1'b1, 1'b1, 32'd508, 1'b0);
    tick("wr_br");
    set_in(1'b1, 1'b0, 32'h0, 1'b0);
    tick("wr_508");
    check("wr_addr508", {23'h0, rom_addr}, 32'd508);
    tick("wr_512");
    check("wr_pc512", pc, 32'd512);
    check("wr_addr0", {23'h0, rom_addr}, 32'd0);
    set_in(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick("wr_tgt");
    set_in(1'b1, 1'b0, 32'h0, 1'b0);
    tick("wr_top");
    check("wr_top_pc", pc, 32'hFFFF_FFFC);
    check("wr_npc0", npc, 32'h0);
    set_in(1'b1, 1'b1, 32'h0000_0013, 1'b0);
    tick("mis_br");
    set_in(1'b1, 1'b0, 32'h0, 1'b0);
    tick("mis_slot");
    check("mis_pc", pc, 32'h13);

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        set_in($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
               ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom,
               $urandom_range(0, 7) == 0);
        tick("rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning the instruction-memory address width driven on rom_addr.
REQ-002 SHALL have parameter PC_RESET, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port le  input  1  load enable; 0 stalls PC, nPC and IF/ID.
REQ-006 SHALL have port branch_taken  input  1  a taken control transfer resolved downstream.
REQ-007 SHALL have port ta  input  32  target address for a taken control transfer.
REQ-008 SHALL have port flush  input  1  squash the instruction held in IF/ID.
REQ-009 SHALL have port rom_data  input  32  instruction word from the combinational 512-byte ROM.
REQ-010 SHALL have port rom_addr  output  ADDR_W  byte address to the ROM, equal to pc[ADDR_W-1:0].
REQ-011 SHALL have port pc  output  32  current program counter.
REQ-012 SHALL have port npc  output  32  next program counter (SPARC-style delayed control).
REQ-013 SHALL have port ifid_instr  output  32  IF/ID pipeline instruction register.
REQ-014 SHALL have port ifid_pc  output  32  PC of the instruction in ifid_instr.
REQ-015 SHALL have port ifid_valid  output  1  ifid_instr holds a real fetched instruction.

Function
REQ-016 SHALL be a two-state FSM: BOOT (entered on reset) and RUN.
REQ-017 In BOOT, on the first rising edge with le=1, the block SHALL load ifid_instr<=rom_data, ifid_pc<=pc, ifid_valid<=1, and SHALL advance PC/nPC as in RUN and move to RUN; with le=0 it SHALL stay in BOOT with all registers held.
REQ-018 In RUN with le=1 and branch_taken=0: pc<=npc; npc<=npc+4; IF/ID<=(rom_data, pc, 1).
REQ-019 In RUN with le=1 and branch_taken=1: pc<=npc (delay slot); npc<=ta; IF/ID<=(rom_data, pc, 1).
REQ-020 With le=0: pc, npc, ifid_instr, ifid_pc, ifid_valid SHALL hold; branch_taken and ta SHALL be ignored.
REQ-021 flush=1 at a rising edge SHALL set ifid_instr<=32'h0 and ifid_valid<=0 regardless of le; ifid_pc SHALL then take pc if le=1, else hold.
REQ-022 With flush=1 and le=1, pc/npc SHALL update per REQ-018/019 (flush squashes IF/ID only).
REQ-023 Priority SHALL be reset > flush (IF/ID only) > le=0 stall > normal update.
REQ-024 npc+4 SHALL wrap modulo 2^32; rom_addr SHALL wrap modulo 2^ADDR_W (pc 512 -> rom_addr 0).
REQ-025 ta SHALL be loaded unmodified; misaligned ta (low two bits nonzero) SHALL NOT be corrected or flagged.
REQ-026 rom_addr SHALL be combinational from the pc register, so rom_data for pc is valid within the same cycle (fetch latency one edge: instruction at pc appears in ifid_instr after the next le=1 edge).

Reset
REQ-027 While reset=1, independent of clk: pc=PC_RESET, npc=PC_RESET+4, ifid_instr=0, ifid_pc=0, ifid_valid=0, FSM=BOOT.
REQ-028 Reset asserted mid-operation SHALL immediately force REQ-027 values, discarding any pending branch or stall; after release, fetch SHALL restart from PC_RESET.
REQ-029 Reset deassertion SHALL take effect only at the next rising edge; no update occurs on the edge coincident with release.

Verification
REQ-030 Sequential fetch: ROM words 0..3 = 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004; reset then le=1 for 4 edges -> ifid_instr A0000001..A0000004, ifid_pc 0,4,8,12, pc ends 16, npc 20.
REQ-031 Delayed branch: at pc=8, npc=12 assert branch_taken=1, ta=32'h40 for one edge -> pc=12, npc=0x40, next edge pc=0x40, npc=0x44; ifid_pc sequence 8,12.
REQ-032 Stall: le=0 for 3 edges at pc=4 -> pc=4, npc=8, ifid_instr/ifid_valid unchanged, branch_taken pulses ignored.
REQ-033 Flush: flush=1 with le=1 at pc=8 -> ifid_instr=0, ifid_valid=0, ifid_pc=8, pc=12; flush=1 with le=0 -> ifid_instr=0, ifid_valid=0, pc held.
REQ-034 Wrap: force pc=508 via ta -> rom_addr=508, next edge pc=512, rom_addr=0; ta=32'hFFFFFFFC path yields npc=32'h00000000 after +4.
REQ-035 Async reset mid-run: assert reset between edges at pc=0x44 -> outputs immediately equal REQ-027 values before the next clk edge; first le=1 edge after release fetches word at address 0.
